scratch_core: RTL and testbench

//  Multi-cycle executor for a subset of RV32I integer instructions. Holds the architectural

---
 rtl/scratch_core.sv | 170 +++++++++++++++++
 tb/tb_scratch_core.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratch_core.sv
// scratch_core: multi-cycle executor for the RV32I OP / OP-IMM / LUI subset with an internal
// register file. One instruction per start handshake: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
module scratch_core #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instructionIn,
    input  logic            start,
    output logic            busy,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic [1:0]      dbg_state
);

    // start/busy handshake: start is taken only on an edge where busy is low (IDLE); that edge
    // latches instructionIn and busy then stays high for exactly 3 cycles. start while busy is ignored.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [31:0]     ir;
    logic [XLEN-1:0] regs [NUM_REGS];
    logic [XLEN-1:0] a_q, b_q, alu_q;
    logic [2:0]      f3_q;
    logic            alt_q, legal_q;
    logic [4:0]      rd_q;

    logic [6:0]      opcode, funct7;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2;
    logic [XLEN-1:0] rs1_val, rs2_val, imm_i, imm_u;
    logic [XLEN-1:0] dec_a, dec_b, alu;
    logic [2:0]      dec_f3;
    logic            dec_alt, dec_legal;
    logic [4:0]      shamt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_DECODE;
            S_DECODE:    state_nxt = S_EXECUTE;
            S_EXECUTE:   state_nxt = S_WRITEBACK;
            S_WRITEBACK: state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    assign opcode  = ir[6:0];
    assign funct3  = ir[14:12];
    assign funct7  = ir[31:25];
    assign rs1     = ir[19:15];
    assign rs2     = ir[24:20];
    assign imm_i   = {{(XLEN-12){ir[31]}}, ir[31:20]};
    assign imm_u   = {ir[31:12], 12'b0};
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    // LUI is folded into the adder as 0 + imm_u so the ALU needs no extra path.
    always_comb begin
        dec_a     = rs1_val;
        dec_b     = rs2_val;
        dec_f3    = funct3;
        dec_alt   = 1'b0;
        dec_legal = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (funct7 == 7'b0000000) begin
                    dec_legal = 1'b1;
                end else if (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_legal = 1'b1;
                    dec_alt   = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_b = imm_i;
                case (funct3)
                    3'b001:  dec_legal = (funct7 == 7'b0000000);
                    3'b101: begin
                        dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                        dec_alt   = funct7[5];
                    end
                    default: dec_legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                dec_a     = '0;
                dec_b     = imm_u;
                dec_f3    = 3'b000;
                dec_legal = 1'b1;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    assign shamt = b_q[4:0];

    always_comb begin
        alu = '0;
        case (f3_q)
            3'b000: alu = alt_q ? (a_q - b_q) : (a_q + b_q);
            3'b001: alu = a_q << shamt;
            3'b010: alu = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            3'b011: alu = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            3'b100: alu = a_q ^ b_q;
            3'b101: alu = alt_q ? $unsigned($signed(a_q) >>> shamt) : (a_q >> shamt);
            3'b110: alu = a_q | b_q;
            3'b111: alu = a_q & b_q;
            default: alu = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            alt_q   <= 1'b0;
            legal_q <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            result  <= '0;
            illegal <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) ir <= instructionIn;
                S_DECODE: begin
                    a_q     <= dec_a;
                    b_q     <= dec_b;
                    f3_q    <= dec_f3;
                    alt_q   <= dec_alt;
                    legal_q <= dec_legal;
                    rd_q    <= ir[11:7];
                end
                S_EXECUTE: alu_q <= alu;
                S_WRITEBACK: begin
                    if (legal_q) begin
                        result  <= alu_q;
                        illegal <= 1'b0;
                        if (rd_q != 5'd0) regs[rd_q] <= alu_q;
                    end else begin
                        illegal <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_scratch_core.sv
// Testbench for scratch_core: spec sequences plus randomized instructions checked against a
// behavioural RV32I-subset model; registers are observed by "add x0, xN, x0" probes.
module tb_scratch_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instructionIn;
    logic        start;
    logic        busy;
    logic [31:0] result;
    logic        illegal;
    logic [1:0]  dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_result;
    logic        m_illegal;
    logic [31:0] exp_q [$];

    scratch_core dut (
        .clk          (clk),
        .reset        (reset),
        .instructionIn(instructionIn),
        .start        (start),
        .busy         (busy),
        .result       (result),
        .illegal      (illegal),
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] probe(input logic [4:0] r);
        return enc_r(7'd0, 5'd0, r, 3'd0, 5'd0);
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [31:0] sra32(input logic [31:0] x, input logic [4:0] sh);
        logic [31:0] v;
        v = x >> sh;
        if (x[31] && sh != 0) v = v | ~(32'hFFFF_FFFF >> sh);
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_result  = 32'd0;
        m_illegal = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_exec(input logic [31:0] ins);
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] x, y, imm, val;
        logic        legal;
        op    = ins[6:0];
        f7    = ins[31:25];
        f3    = ins[14:12];
        rd    = ins[11:7];
        x     = m_regs[ins[19:15]];
        y     = m_regs[ins[24:20]];
        imm   = {{20{ins[31]}}, ins[31:20]};
        val   = 32'd0;
        legal = 1'b1;
        if (op == 7'b0110011) begin
            if (f7 == 7'h00) begin
                case (f3)
                    3'd0: val = x + y;
                    3'd1: val = x << y[4:0];
                    3'd2: val = (int'(x) < int'(y)) ? 32'd1 : 32'd0;
                    3'd3: val = (x < y) ? 32'd1 : 32'd0;
                    3'd4: val = x ^ y;
                    3'd5: val = x >> y[4:0];
                    3'd6: val = x | y;
                    default: val = x & y;
                endcase
            end else if (f7 == 7'h20 && f3 == 3'd0) val = x - y;
            else if (f7 == 7'h20 && f3 == 3'd5) val = sra32(x, y[4:0]);
            else legal = 1'b0;
        end else if (op == 7'b0010011) begin
            case (f3)
                3'd0: val = x + imm;
                3'd2: val = (int'(x) < int'(imm)) ? 32'd1 : 32'd0;
                3'd3: val = (x < imm) ? 32'd1 : 32'd0;
                3'd4: val = x ^ imm;
                3'd6: val = x | imm;
                3'd7: val = x & imm;
                3'd1: begin legal = (f7 == 7'h00); val = x << imm[4:0]; end
                default: begin
                    if (f7 == 7'h00) val = x >> imm[4:0];
                    else if (f7 == 7'h20) val = sra32(x, imm[4:0]);
                    else legal = 1'b0;
                end
            endcase
        end else if (op == 7'b0110111) begin
            val = {ins[31:12], 12'h000};
        end else begin
            legal = 1'b0;
        end
        if (legal) begin
            if (rd != 5'd0) m_regs[rd] = val;
            m_result  = val;
            m_illegal = 1'b0;
        end else begin
            m_illegal = 1'b1;
        end
        exp_q.push_back(m_result);
    endfunction

    function automatic logic [31:0] gen_rand();
        logic [31:0] r;
        logic [6:0]  f7;
        logic [2:0]  f3;
        int          k, idx;
        r = $urandom();
        k = $urandom_range(0, 9);
        case (k)
            0, 1, 2, 3: begin
                idx = $urandom_range(0, 9);
                f7  = (idx >= 8) ? 7'h20 : 7'h00;
                f3  = (idx == 8) ? 3'd0 : (idx == 9) ? 3'd5 : 3'(idx);
                return enc_r(f7, r[24:20], r[19:15], f3, r[11:7]);
            end
            4, 5: begin
                case ($urandom_range(0, 5))
                    0: f3 = 3'd0; 1: f3 = 3'd2; 2: f3 = 3'd3;
                    3: f3 = 3'd4; 4: f3 = 3'd6; default: f3 = 3'd7;
                endcase
                return enc_i(r[31:20], r[19:15], f3, r[11:7]);
            end
            6: begin
                f3 = r[0] ? 3'd5 : 3'd1;
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00; 1: f7 = 7'h20; default: f7 = r[31:25];
                endcase
                return enc_i({f7, r[24:20]}, r[19:15], f3, r[11:7]);
            end
            7: return {r[31:12], r[11:7], 7'b0110111};
            8: return enc_r(r[31:25], r[24:20], r[19:15], r[14:12], r[11:7]);
            default: return r;
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] ins, output int cycles, output bit timeout);
        @(negedge clk);
        instructionIn = ins;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        instructionIn = $urandom();
        cycles  = 0;
        timeout = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) cycles++;
            else begin
                timeout = 1'b0;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        instructionIn = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++;
        if (result !== 32'd0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
        n_vec++;
        if (illegal !== 1'b0) begin n_err++; $display("FAIL reset_illegal got %b want 0", illegal); end
        n_vec++;
        if (dbg_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        reset = 1'b1;
    endtask

    task automatic test_spec_sequence();
        logic [31:0] ins [16];
        logic [31:0] want [16];
        logic        want_ill [16];
        int cyc;
        bit to;
        logic [31:0] e;
        ins[0]  = 32'h01200293; want[0]  = 32'd18;        want_ill[0]  = 0;
        ins[1]  = 32'h01800313; want[1]  = 32'd24;        want_ill[1]  = 0;
        ins[2]  = 32'h00530e33; want[2]  = 32'd42;        want_ill[2]  = 0;
        ins[3]  = 32'h000e0fb3; want[3]  = 32'd42;        want_ill[3]  = 0;
        ins[4]  = probe(5'd5);  want[4]  = 32'd18;        want_ill[4]  = 0;
        ins[5]  = probe(5'd6);  want[5]  = 32'd24;        want_ill[5]  = 0;
        ins[6]  = probe(5'd28); want[6]  = 32'd42;        want_ill[6]  = 0;
        ins[7]  = probe(5'd31); want[7]  = 32'd42;        want_ill[7]  = 0;
        ins[8]  = 32'hfff00293; want[8]  = 32'hFFFF_FFFF; want_ill[8]  = 0;
        ins[9]  = enc_r(7'd0, 5'd0, 5'd5, 3'd2, 5'd7);   want[9]  = 32'd1; want_ill[9] = 0;
        ins[10] = enc_r(7'd0, 5'd0, 5'd5, 3'd3, 5'd9);   want[10] = 32'd0; want_ill[10] = 0;
        ins[11] = enc_i(12'h404, 5'd5, 3'd5, 5'd10);     want[11] = 32'hFFFF_FFFF; want_ill[11] = 0;
        ins[12] = enc_i(12'h004, 5'd5, 3'd5, 5'd11);     want[12] = 32'h0FFF_FFFF; want_ill[12] = 0;
        ins[13] = 32'h00500013; want[13] = 32'd5;         want_ill[13] = 0;
        ins[14] = 32'h00000000; want[14] = 32'd5;         want_ill[14] = 1;
        ins[15] = probe(5'd0);  want[15] = 32'd0;         want_ill[15] = 0;
        for (int i = 0; i < 16; i++) begin
            issue(ins[i], cyc, to);
            model_exec(ins[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (to || cyc != 3) begin
                n_err++;
                $display("FAIL spec_busy_len[%0d] got %0d cycles (timeout=%0b) want 3", i, cyc, to);
            end
            n_vec++;
            if (result !== want[i] || result !== e) begin
                n_err++;
                $display("FAIL spec_result[%0d] ins=%h got %h want %h", i, ins[i], result, want[i]);
            end
            n_vec++;
            if (illegal !== want_ill[i]) begin
                n_err++;
                $display("FAIL spec_illegal[%0d] got %b want %b", i, illegal, want_ill[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] ins_a, ins_b, e;
        int cyc;
        bit to;
        ins_a = enc_i(12'd11, 5'd0, 3'd0, 5'd7);
        ins_b = enc_i(12'd99, 5'd0, 3'd0, 5'd8);
        @(negedge clk);
        instructionIn = ins_a;
        start = 1'b1;
        @(posedge clk);
        #1;
        instructionIn = ins_b;
        cyc = 0;
        to  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (busy) cyc++;
            else begin
                to = 1'b0;
                break;
            end
        end
        start = 1'b0;
        model_exec(ins_a);
        e = exp_q.pop_front();
        n_vec++;
        if (to || cyc != 3) begin
            n_err++;
            $display("FAIL swb_busy_len got %0d cycles (timeout=%0b) want 3", cyc, to);
        end
        n_vec++;
        if (result !== e) begin n_err++; $display("FAIL swb_result got %h want %h", result, e); end
        issue(probe(5'd8), cyc, to);
        model_exec(probe(5'd8));
        e = exp_q.pop_front();
        n_vec++;
        if (to || result !== e) begin n_err++; $display("FAIL swb_x8_untouched got %h want %h", result, e); end
        issue(probe(5'd7), cyc, to);
        model_exec(probe(5'd7));
        e = exp_q.pop_front();
        n_vec++;
        if (to || result !== e) begin n_err++; $display("FAIL swb_x7 got %h want %h", result, e); end
    endtask

    task automatic test_reset_midflight();
        logic [31:0] ins, e;
        int cyc;
        bit to;
        ins = enc_i(12'd7, 5'd0, 3'd0, 5'd5);
        @(negedge clk);
        instructionIn = ins;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #2;
        n_vec++;
        if (dbg_state !== 2'd2) begin n_err++; $display("FAIL midrst_in_execute got %0d want 2", dbg_state); end
        reset = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy); end
        n_vec++;
        if (result !== 32'd0 || illegal !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_outputs got result=%h illegal=%b want 0/0", result, illegal);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        issue(probe(5'd5), cyc, to);
        model_exec(probe(5'd5));
        e = exp_q.pop_front();
        n_vec++;
        if (to || result !== e) begin n_err++; $display("FAIL midrst_x5_clear got %h want %h", result, e); end
        issue(ins, cyc, to);
        model_exec(ins);
        e = exp_q.pop_front();
        n_vec++;
        if (to || cyc != 3 || result !== e) begin
            n_err++;
            $display("FAIL midrst_rerun got %h cycles=%0d want %h cycles=3", result, cyc, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [7];
        logic [31:0] e;
        int cyc;
        bit to;
        ins[0] = enc_i(12'(32'($urandom_range(1, 2047))), 5'd0, 3'd0, 5'd1);
        ins[1] = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
        ins[2] = enc_r(7'h00, 5'd1, 5'd2, 3'd0, 5'd3);
        ins[3] = enc_r(7'h20, 5'd3, 5'd1, 3'd0, 5'd4);
        ins[4] = enc_r(7'h20, 5'd1, 5'd4, 3'd5, 5'd4);
        ins[5] = enc_r(7'h00, 5'd4, 5'd3, 3'd2, 5'd5);
        ins[6] = probe(5'd4);
        @(negedge clk);
        start = 1'b1;
        instructionIn = ins[0];
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            instructionIn = $urandom();
            cyc = 0;
            to  = 1'b1;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (busy) cyc++;
                else begin
                    to = 1'b0;
                    break;
                end
            end
            model_exec(ins[i]);
            e = exp_q.pop_front();
            n_vec++;
            if (to || cyc != 3 || result !== e || illegal !== 1'b0) begin
                n_err++;
                $display("FAIL b2b[%0d] got %h cycles=%0d ill=%b want %h cycles=3 ill=0",
                         i, result, cyc, illegal, e);
            end
            if (i < 6) instructionIn = ins[i+1];
            else start = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [31:0] ins, e;
        int cyc;
        bit to;
        for (int i = 0; i < 240; i++) begin
            ins = (i % 4 == 3) ? probe(5'($urandom_range(0, 31))) : gen_rand();
            issue(ins, cyc, to);
            model_exec(ins);
            e = exp_q.pop_front();
            n_vec++;
            if (to || cyc != 3 || result !== e || illegal !== m_illegal) begin
                n_err++;
                $display("FAIL rand[%0d] ins=%h got %h ill=%b cycles=%0d want %h ill=%b cycles=3",
                         i, ins, result, illegal, cyc, e, m_illegal);
            end
        end
    endtask

    initial begin
        test_reset();
        test_spec_sequence();
        test_start_while_busy();
        test_reset_midflight();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
